// File: rtl/wb_bus_timeout_if.sv
// Wishbone link between the Caravel master, the timeout guard and the bus splitter.
// The slave modport is the guard's own view; the master modport is the surrounding environment's view.
interface wb_bus_timeout_if;
    logic        m_wb_cyc_i;
    logic        m_wb_stb_i;
    logic        m_wb_we_i;
    logic [3:0]  m_wb_sel_i;
    logic [31:0] m_wb_adr_i;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_o;
    logic        m_wb_err_o;
    logic [31:0] m_wb_dat_o;

    logic        s_wb_cyc_o;
    logic        s_wb_stb_o;
    logic        s_wb_we_o;
    logic [3:0]  s_wb_sel_o;
    logic [31:0] s_wb_adr_o;
    logic [31:0] s_wb_dat_o;
    logic [31:0] s_wb_dat_i;
    logic        s_wb_ack_i;
    logic        s_wb_err_i;

    modport slave (
        input  m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_sel_i, m_wb_adr_i, m_wb_dat_i,
        output m_wb_ack_o, m_wb_err_o, m_wb_dat_o,
        output s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o,
        input  s_wb_dat_i, s_wb_ack_i, s_wb_err_i
    );

    modport master (
        output m_wb_cyc_i, m_wb_stb_i, m_wb_we_i, m_wb_sel_i, m_wb_adr_i, m_wb_dat_i,
        input  m_wb_ack_o, m_wb_err_o, m_wb_dat_o,
        input  s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o,
        output s_wb_dat_i, s_wb_ack_i, s_wb_err_i
    );
endinterface

// File: rtl/wb_bus_timeout.sv
// Wishbone watchdog: passes accesses through and forces a one-cycle fault response
// when the downstream slave leaves a strobed access unacknowledged for TIMEOUT_CYCLES.
module wb_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RESP_ERR       = 1'b1,
    parameter logic [31:0] FAULT_DATA     = 32'hDEADBEEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_bus_timeout_if.slave    bus,
    input  logic               irq_clr_i,
    output logic               timeout_irq,
    output logic [31:0]        fault_adr_o,
    output logic [7:0]         fault_cnt_o
);
    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ABORT} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_irq;
    logic [31:0]   r_fault_adr;
    logic [7:0]    r_fault_cnt;
    logic          w_req, w_resp, w_abort;

    assign w_req  = bus.m_wb_cyc_i & bus.m_wb_stb_i;
    assign w_resp = bus.s_wb_ack_i | bus.s_wb_err_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_irq       <= 1'b0;
            r_fault_adr <= '0;
            r_fault_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_abort) begin
                r_fault_adr <= bus.m_wb_adr_i;
                if (r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
            end
            // A clear landing on the abort edge loses to the new fault.
            if (w_abort)        r_irq <= 1'b1;
            else if (irq_clr_i) r_irq <= 1'b0;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_resp) begin
                    w_next    = S_WAIT;
                    w_cnt_nxt = CW'(1);
                end
            end
            S_WAIT: begin
                // A response in the final allowed cycle still counts as a normal completion.
                if (!bus.m_wb_cyc_i || w_resp) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_next    = S_ABORT;
                    w_cnt_nxt = '0;
                    w_abort   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_ABORT: begin
                w_next    = S_IDLE;
                w_cnt_nxt = '0;
            end
            default: begin
                w_next    = S_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.s_wb_cyc_o = bus.m_wb_cyc_i;
        bus.s_wb_stb_o = bus.m_wb_stb_i;
        bus.s_wb_we_o  = bus.m_wb_we_i;
        bus.s_wb_sel_o = bus.m_wb_sel_i;
        bus.s_wb_adr_o = bus.m_wb_adr_i;
        bus.s_wb_dat_o = bus.m_wb_dat_i;
        bus.m_wb_ack_o = bus.s_wb_ack_i;
        bus.m_wb_err_o = bus.s_wb_err_i;
        bus.m_wb_dat_o = bus.s_wb_dat_i;
        // Stray slave responses outside any cycle must not reach the master.
        if (r_state == S_IDLE && !bus.m_wb_cyc_i) begin
            bus.m_wb_ack_o = 1'b0;
            bus.m_wb_err_o = 1'b0;
        end
        if (r_state == S_ABORT) begin
            bus.s_wb_cyc_o = 1'b0;
            bus.s_wb_stb_o = 1'b0;
            bus.m_wb_ack_o = ~RESP_ERR;
            bus.m_wb_err_o = RESP_ERR;
            bus.m_wb_dat_o = FAULT_DATA;
        end
    end

    assign timeout_irq = r_irq;
    assign fault_adr_o = r_fault_adr;
    assign fault_cnt_o = r_fault_cnt;
endmodule
